// File: rtl/program_loader.sv
// program_loader: receives a byte-serial program image and writes it into
// instruction memory, then releases the core from reset.
// Stream format: 16-bit little-endian word count N, then N little-endian words.
module program_loader #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_run,
  output logic        load_err
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;

  state_t      state, state_nx;
  logic [15:0] n_hdr;      // word count from the header
  logic [15:0] hdr_n;      // header value as seen during the HDR1 accept
  logic [16:0] wcnt;       // words assembled so far; wide enough for N=DEPTH
  logic [1:0]  bcnt;       // byte position within the current word
  logic [23:0] wbuf;       // first three bytes of the word in progress
  logic        last_pend;  // final word assembled, its write pulse is next
  logic        accept;

  assign accept = in_valid & in_ready;
  assign hdr_n  = {in_data, n_hdr[7:0]};

  // State register; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (rst) state <= HDR0;
    else     state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  // in_ready drops once the final word is assembled so no stray byte is
  // consumed during the last write pulse.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    core_run = 1'b0;
    load_err = 1'b0;
    case (state)
      HDR0: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = HDR1;
      end
      HDR1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (hdr_n == 16'd0)                state_nx = DONE;
          else if ({16'd0, hdr_n} > DEPTH)   state_nx = ERR;
          else                               state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = !last_pend;
        if (imem_we && last_pend) state_nx = DONE;
      end
      DONE:    core_run = 1'b1;
      ERR:     load_err = 1'b1;
      default: state_nx = HDR0;
    endcase
  end

  // Header capture, word assembly, write strobe and address generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_hdr      <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      wbuf       <= '0;
      last_pend  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      // Address moves on after each write except the last, so it stops at 4*(N-1).
      if (imem_we && !last_pend) imem_addr <= imem_addr + 32'd4;
      if (accept) begin
        case (state)
          HDR0: n_hdr[7:0]  <= in_data;
          HDR1: n_hdr[15:8] <= in_data;
          DATA: begin
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: wbuf[7:0]   <= in_data;
              2'd1: wbuf[15:8]  <= in_data;
              2'd2: wbuf[23:16] <= in_data;
              default: begin
                imem_wdata <= {in_data, wbuf};
                imem_we    <= 1'b1;
                wcnt       <= wcnt + 17'd1;
                last_pend  <= ((wcnt + 17'd1) == {1'b0, n_hdr});
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader with hand-computed expectations.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, core_run, load_err;
  logic [31:0] imem_addr, imem_wdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t  wq[$];
  int   cyc = 0;
  int   we_cyc = 0;
  int   run_cyc = 0;
  bit   run_seen = 1'b0;
  bit   prev_we = 1'b0;
  int   dbl = 0;

  program_loader #(.DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_run  (core_run),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write / run-start recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back('{imem_addr, imem_wdata});
      we_cyc = cyc;
    end
    if (imem_we && prev_we) dbl++;
    prev_we = imem_we;
    if (core_run && !run_seen) begin
      run_seen = 1'b1;
      run_cyc  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Move to just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    step();
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    step();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    step();
    rst = 1'b0;
    wq.delete();
    run_seen = 1'b0;
    dbl      = 0;
  endtask

  function automatic logic [31:0] w35(input int k);
    return {8'(k), 8'(k >> 8) ^ 8'h3C, 8'(k * 7), 8'hA5 ^ 8'(k)};
  endfunction

  logic [7:0] s30 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h33, 8'h06, 8'hB5, 8'h00};
  bit         v33 [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] d33 [4]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    int bi;
    int nbad;
    logic [31:0] w;

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we",       32'(imem_we),  32'd0);
    check("rst_addr",     imem_addr,     32'h0);
    check("rst_wdata",    imem_wdata,    32'h0);
    check("rst_run",      32'(core_run), 32'd0);
    check("rst_err",      32'(load_err), 32'd0);

    // Two-word load with in_valid held high
    for (int i = 0; i < 10; i++) send_byte(s30[i]);
    step();
    check("s30_we2",    32'(imem_we),  32'd1);
    check("s30_addr2",  imem_addr,     32'h4);
    check("s30_data2",  imem_wdata,    32'h00B50633);
    check("s30_run0",   32'(core_run), 32'd0);
    step();
    in_valid = 1'b0;
    check("s30_run1",   32'(core_run), 32'd1);
    check("s30_we_off", 32'(imem_we),  32'd0);
    check("s30_rdy_off", 32'(in_ready), 32'd0);
    check("s30_nwr",    32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("s30_q_a0", wq[0].a, 32'h0);
      check("s30_q_d0", wq[0].d, 32'h00A00513);
      check("s30_q_a1", wq[1].a, 32'h4);
      check("s30_q_d1", wq[1].d, 32'h00B50633);
    end
    check("s30_run_lat", 32'(run_cyc - we_cyc), 32'd1);
    check("s30_single",  32'(dbl), 32'd0);

    // Empty program
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    step();
    check("s31_run",   32'(core_run), 32'd1);
    check("s31_rdy",   32'(in_ready), 32'd0);
    idle(3);
    check("s31_nwr",   32'(wq.size()), 32'd0);
    check("s31_run_h", 32'(core_run), 32'd1);

    // Header over capacity (N=1025)
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    step();
    check("s32_err", 32'(load_err), 32'd1);
    check("s32_rdy", 32'(in_ready), 32'd0);
    idle(3);
    check("s32_run", 32'(core_run), 32'd0);
    check("s32_nwr", 32'(wq.size()), 32'd0);
    check("s32_err_h", 32'(load_err), 32'd1);

    // N=1 with in_valid gaps; garbage on idle cycles must be ignored
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    bi = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      in_valid = v33[i];
      if (v33[i]) begin
        in_data = d33[bi];
        bi++;
      end else begin
        in_data = 8'h55;
      end
      check("s33_rdy", 32'(in_ready), 32'd1);
      check("s33_we0", 32'(imem_we), 32'd0);
    end
    step();
    in_valid = 1'b0;
    check("s33_we",   32'(imem_we), 32'd1);
    check("s33_addr", imem_addr,    32'h0);
    check("s33_data", imem_wdata,   32'hDEADBEEF);
    step();
    check("s33_run",  32'(core_run), 32'd1);
    check("s33_nwr",  32'(wq.size()), 32'd1);

    // Reset mid-load, pending-write suppression, then fresh load
    do_reset();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    step();
    check("s34_we0",   32'(imem_we),  32'd1);
    check("s34_rdy_w", 32'(in_ready), 32'd1);
    check("s34_a0",    imem_addr,     32'h0);
    check("s34_d0",    imem_wdata,    32'h40302010);
    in_valid = 1'b1;
    in_data  = 8'h50;
    @(posedge clk);
    send_byte(8'h60); send_byte(8'h70); send_byte(8'h80);
    send_byte(8'h90); send_byte(8'hA0);
    step();
    in_valid = 1'b0;
    check("s34_addr8", imem_addr, 32'h8);
    rst = 1'b1;
    @(posedge clk);
    step();
    rst = 1'b0;
    check("s34_r_addr", imem_addr,    32'h0);
    check("s34_r_rdy",  32'(in_ready), 32'd1);
    idle(3);
    check("s34_nwr",    32'(wq.size()), 32'd2);
    wq.delete();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    step();
    in_valid = 1'b1;
    in_data  = 8'h44;
    rst      = 1'b1;
    @(posedge clk);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("s34_sup_we",  32'(imem_we),  32'd0);
    check("s34_sup_rdy", 32'(in_ready), 32'd1);
    idle(2);
    check("s34_sup_nwr", 32'(wq.size()), 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
    step();
    in_valid = 1'b0;
    check("s34_f_we",   32'(imem_we), 32'd1);
    check("s34_f_addr", imem_addr,    32'h0);
    check("s34_f_data", imem_wdata,   32'hAABBCCDD);
    step();
    check("s34_f_run",  32'(core_run), 32'd1);

    // Full-capacity load (N=DEPTH) with random idle gaps
    do_reset();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int k = 0; k < 1024; k++) begin
      w = w35(k);
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 2) == 0) begin
          step();
          in_valid = 1'b0;
          @(posedge clk);
        end
        send_byte(w[8*j +: 8]);
      end
      if (k < 1023 && core_run) check("s35_early_run", 32'(core_run), 32'd0);
    end
    step();
    in_valid = 1'b0;
    check("s35_we",   32'(imem_we),  32'd1);
    check("s35_addr", imem_addr,     32'hFFC);
    check("s35_run0", 32'(core_run), 32'd0);
    step();
    check("s35_run1", 32'(core_run), 32'd1);
    check("s35_addr_hold", imem_addr, 32'hFFC);
    check("s35_run_lat", 32'(run_cyc - we_cyc), 32'd1);
    check("s35_nwr", 32'(wq.size()), 32'd1024);
    nbad = 0;
    if (wq.size() == 1024) begin
      for (int k = 0; k < 1024; k++) begin
        if (wq[k].a !== 32'(4 * k) || wq[k].d !== w35(k)) nbad++;
      end
    end
    check("s35_words",  32'(nbad), 32'd0);
    check("s35_single", 32'(dbl),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the instruction memory capacity in 32-bit words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning a byte is offered on in_data.
REQ-005 SHALL have port in_data, input, 8, meaning the load-stream byte.
REQ-006 SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-007 SHALL have port imem_we, output, 1, meaning the instruction-memory write strobe.
REQ-008 SHALL have port imem_addr, output, 32, meaning the byte address of the write, always word-aligned.
REQ-009 SHALL have port imem_wdata, output, 32, meaning the instruction word to write.
REQ-010 SHALL have port core_run, output, 1, meaning the core may leave reset; it drives the core's active-low rst.
REQ-011 SHALL have port load_err, output, 1, meaning the header word count exceeds DEPTH.

Function
REQ-012 SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1, with no other byte consumption.
REQ-013 SHALL use states HDR0, HDR1, DATA, DONE and ERR, and SHALL enter HDR0 on reset.
REQ-014 SHALL assert in_ready in HDR0, HDR1 and DATA only, and SHALL never depend combinationally on in_valid.
REQ-015 SHALL take header N as a 16-bit little-endian value: the HDR0 byte is N[7:0] and the HDR1 byte is N[15:8].
REQ-016 SHALL, on HDR1 accept, go to DONE if N=0, to ERR if N>DEPTH, and to DATA otherwise.
REQ-017 SHALL assemble each word little-endian: the 1st data byte goes to [7:0] and the 4th to [31:24].
REQ-018 SHALL pulse imem_we for exactly one cycle, on the cycle after the 4th byte of a word is accepted, with imem_wdata holding the assembled word.
REQ-019 SHALL drive imem_addr = 4*k during the write of word k, counting k from 0; the address advances by 4 after each write.
REQ-020 SHALL hold in_ready high during the write pulse, so a new word's first byte may be accepted in the same cycle as the previous word's write.
REQ-021 SHALL move from DATA to DONE when the N-th word's write pulse occurs, so that core_run rises on the cycle after the final imem_we.
REQ-022 SHALL, in DONE, hold core_run=1, in_ready=0 and imem_we=0 until rst.
REQ-023 SHALL, in ERR, hold load_err=1, core_run=0, in_ready=0 and imem_we=0 until rst, and SHALL perform no memory writes.
REQ-024 SHALL use a word counter of at least 17 bits so that N=DEPTH completes without wrap; imem_addr SHALL never exceed 4*(DEPTH-1).
REQ-025 SHALL leave a partial word (fewer than 4 bytes) pending with no write until further bytes arrive; there SHALL be no timeout.
REQ-026 SHALL freeze all state while in_valid=0, with no accept and no counter advance.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, give the following values on the next cycle: state HDR0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_run=0, load_err=0, and byte and word counters cleared.
REQ-028 SHALL discard any partially assembled word and suppress any pending write pulse when rst is asserted mid-load, including during DATA.
REQ-029 SHALL give rst priority over every simultaneous event, including a byte accept or a write.

Verification
REQ-030 SHALL cover this scenario: stream 02 00, 13 05 A0 00, 33 06 B5 00 with in_valid held high -> writes at addr 0x0 data 0x00A00513 and at addr 0x4 data 0x00B50633, each a single-cycle imem_we; core_run=1 one cycle after the second write.
REQ-031 SHALL cover this scenario: stream 00 00 -> core_run=1 after HDR1 with no imem_we pulse and in_ready=0 thereafter.
REQ-032 SHALL cover this scenario: header 01 04 (N=1025) with DEPTH=1024 -> load_err=1, in_ready=0, core_run stays 0, no writes.
REQ-033 SHALL cover this scenario: N=1 with in_valid toggling 1,0,0,1,0,1,1 -> exactly one write with correct byte order; counters do not advance on idle cycles.
REQ-034 SHALL cover this scenario: rst pulsed after 2 data bytes of the word at addr 0x8 -> no write occurs; a fresh header N=1 plus 4 bytes then writes addr 0x0 and raises core_run.
REQ-035 SHALL cover this scenario: N=DEPTH with random in_valid gaps -> final write at addr 4*(DEPTH-1), no wrap, and core_run=1 only after that final write.
